// File: rtl/mlab_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the MLAB show-ahead FIFO.
package mlab_fifo_pkg;

    localparam string FAMILY_AGILEX = "Agilex";
    localparam string FAMILY_S10    = "S10";
    localparam string FAMILY_OTHER  = "Other";

    // Cycles between a push and the word becoming fetchable from the RAM.
    function automatic int rd_lag(input string family);
        return (family == FAMILY_S10) ? 2 : 1;
    endfunction

    function automatic int clog2_depth(input int depth);
        int n;
        n = 0;
        while ((1 << n) < depth) n++;
        return n;
    endfunction

endpackage

// File: rtl/generic_mlab_dc.sv
// Simple dual-port MLAB model with a registered read port; S10 also registers
// the write side, so a write lands in the array one edge after it is presented.
module generic_mlab_dc
    import mlab_fifo_pkg::*;
#(
    parameter int    WIDTH      = 8,
    parameter int    ADDR_WIDTH = 5,
    parameter string FAMILY     = FAMILY_OTHER
) (
    input  logic                  wclk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rclk,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      dout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;

    if (rd_lag(FAMILY) == 2) begin : g_wreg
        // Unreset like the hard block; a stray write before the first clean
        // edge only touches contents the owner treats as empty.
        always_ff @(posedge wclk) begin
            wr_en   <= we;
            wr_addr <= waddr;
            wr_data <= din;
        end
    end else begin : g_wdirect
        assign wr_en   = we;
        assign wr_addr = waddr;
        assign wr_data = din;
    end

    // NOTE: the storage array has no reset; only control state needs a known
    // value, and resetting memory would prevent mapping onto MLAB cells.
    always_ff @(posedge wclk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge rclk) begin
        if (re) dout <= mem[raddr];
    end

endmodule

// File: rtl/mlab_showahead_fifo.sv
// Single-clock show-ahead FIFO: pointers, counts and handshakes around one
// MLAB whose read register doubles as the head word.
module mlab_showahead_fifo
    import mlab_fifo_pkg::*;
#(
    parameter int    WIDTH      = 8,
    parameter int    ADDR_WIDTH = 5,
    parameter string FAMILY     = FAMILY_OTHER
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  sclr,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   used_words,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int CNT_WIDTH = clog2_depth(DEPTH) + 1;
    localparam int LAG       = rd_lag(FAMILY);

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [CNT_WIDTH-1:0]  ram_cnt, rd_avail;
    logic [CNT_WIDTH-1:0]  ram_cnt_next, rd_avail_next, used_next;
    logic                  push, pop, fetch, push_d1, avail_inc, m_valid_next;

    // NOTE: every signal is assigned on every pass, so no latch can be inferred.
    always_comb begin
        push          = s_valid & s_ready & ~sclr;
        pop           = m_valid & m_ready & ~sclr;
        fetch         = (rd_avail != '0) & (~m_valid | m_ready) & ~sclr;
        avail_inc     = (LAG == 2) ? push_d1 : push;
        ram_cnt_next  = ram_cnt + CNT_WIDTH'(push) - CNT_WIDTH'(fetch);
        rd_avail_next = rd_avail + CNT_WIDTH'(avail_inc) - CNT_WIDTH'(fetch);
        m_valid_next  = fetch | (m_valid & ~pop);
        used_next     = ram_cnt_next + CNT_WIDTH'(m_valid_next);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_cnt    <= '0;
            rd_avail   <= '0;
            push_d1    <= 1'b0;
            m_valid    <= 1'b0;
            s_ready    <= 1'b0;
            used_words <= '0;
            empty      <= 1'b1;
        end else if (sclr) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_cnt    <= '0;
            rd_avail   <= '0;
            push_d1    <= 1'b0;
            m_valid    <= 1'b0;
            s_ready    <= 1'b1;
            used_words <= '0;
            empty      <= 1'b1;
        end else begin
            if (push)  wptr <= wptr + ADDR_WIDTH'(1);
            if (fetch) rptr <= rptr + ADDR_WIDTH'(1);
            ram_cnt    <= ram_cnt_next;
            rd_avail   <= rd_avail_next;
            push_d1    <= push;
            m_valid    <= m_valid_next;
            s_ready    <= ram_cnt_next < CNT_WIDTH'(DEPTH);
            used_words <= used_next;
            empty      <= used_next == '0;
        end
    end

    assign full = ~s_ready;

    // A fetch only targets words counted in rd_avail, which were written in an
    // earlier cycle, so the read and write addresses never collide.
    generic_mlab_dc #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FAMILY     (FAMILY)
    ) u_ram (
        .wclk  (clk),
        .we    (push),
        .waddr (wptr),
        .din   (s_data),
        .rclk  (clk),
        .re    (fetch),
        .raddr (rptr),
        .dout  (m_data)
    );

endmodule

// File: tb/tb_mlab_showahead_fifo.sv
// Directed and scoreboarded bench for mlab_showahead_fifo (default FAMILY, DEPTH=32).
module tb_mlab_showahead_fifo;

    localparam int WIDTH      = 8;
    localparam int ADDR_WIDTH = 5;

    logic                clk = 1'b0;
    logic                arst_n = 1'b0;
    logic                sclr = 1'b0;
    logic [WIDTH-1:0]    s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [WIDTH-1:0]    m_data;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [ADDR_WIDTH:0] used_words;
    logic                empty;
    logic                full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mlab_showahead_fifo #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FAMILY     ("Other")
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .sclr       (sclr),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .used_words (used_words),
        .empty      (empty),
        .full       (full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({s_ready, m_valid, used_words, empty, full} !== {1'b0, 1'b0, 6'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b used=%0d empty=%b full=%b, expected 0 0 0 1 1",
                     s_ready, m_valid, used_words, empty, full);
        end
        #2 arst_n = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: s_ready=%b expected 0", s_ready);
        end
        tick();
        n_checks++;
        if (s_ready !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_release: s_ready=%b full=%b expected 1 0", s_ready, full);
        end
    endtask

    task automatic test_single_push();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || used_words !== 6'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL single_edge1: m_valid=%b used=%0d empty=%b expected 0 1 0", m_valid, used_words, empty);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || used_words !== 6'd1) begin
            n_fail++;
            $display("FAIL single_edge2: m_valid=%b m_data=%h used=%0d expected 1 a5 1", m_valid, m_data, used_words);
        end
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || empty !== 1'b1 || used_words !== 6'd0) begin
            n_fail++;
            $display("FAIL single_pop: m_valid=%b empty=%b used=%0d expected 0 1 0", m_valid, empty, used_words);
        end
        tick();
    endtask

    task automatic test_fill_drain();
        int got;
        m_ready = 1'b0;
        for (int i = 0; i < 34; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            @(negedge clk);
            n_checks++;
            if (s_ready !== (i < 33)) begin
                n_fail++;
                $display("FAIL fill_ready[%0d]: s_ready=%b expected %b", i, s_ready, (i < 33));
            end
            tick();
        end
        s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (used_words !== 6'd33 || full !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'd0) begin
            n_fail++;
            $display("FAIL fill_level: used=%0d full=%b m_valid=%b m_data=%h expected 33 1 1 00",
                     used_words, full, m_valid, m_data);
        end
        tick();
        m_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 33; cyc++) begin
            @(negedge clk);
            if (m_valid) begin
                n_checks++;
                if (m_data !== 8'(got)) begin
                    n_fail++;
                    $display("FAIL drain_data[%0d]: m_data=%h expected %h", got, m_data, 8'(got));
                end
                got++;
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (got != 33 || m_valid !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_end: words=%0d m_valid=%b empty=%b expected 33 0 1", got, m_valid, empty);
        end
        m_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int sent, got;
        bit started;
        sent = 0;
        got = 0;
        started = 1'b0;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
            s_valid = (sent < 100);
            s_data  = 8'(sent * 3 + 1);
            @(negedge clk);
            if (s_valid) begin
                n_checks++;
                if (s_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: s_ready=%b expected 1", sent, s_ready);
                end
                if (s_ready) sent++;
            end
            if (started || m_valid) begin
                n_checks++;
                if (m_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_bubble[%0d]: m_valid=%b expected 1", got, m_valid);
                end else if (m_data !== 8'(got * 3 + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: m_data=%h expected %h", got, m_data, 8'(got * 3 + 1));
                end
                if (m_valid) got++;
                started = 1'b1;
            end
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        n_checks++;
        if (got != 100) begin
            n_fail++;
            $display("FAIL b2b_count: received=%0d expected 100", got);
        end
        tick();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] exp;
        int pushed, popped;
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 20000 && popped < 2000; cyc++) begin
            s_valid = (pushed < 2000) && ($urandom_range(0, 1) == 1);
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            n_checks++;
            if (int'(used_words) != q.size() || used_words > 6'd33) begin
                n_fail++;
                $display("FAIL rand_used[%0d]: used=%0d expected %0d", cyc, used_words, q.size());
            end
            if (m_valid && m_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_underflow[%0d]: m_data=%h expected no word", cyc, m_data);
                end else begin
                    exp = q.pop_front();
                    if (m_data !== exp) begin
                        n_fail++;
                        $display("FAIL rand_data[%0d]: m_data=%h expected %h", popped, m_data, exp);
                    end
                end
                popped++;
            end
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                pushed++;
            end
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        n_checks++;
        if (popped != 2000) begin
            n_fail++;
            $display("FAIL rand_count: popped=%0d expected 2000", popped);
        end
        tick();
    endtask

    task automatic test_sclr();
        int waited;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h10 + i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (used_words !== 6'd10 || m_valid !== 1'b1 || m_data !== 8'h10) begin
            n_fail++;
            $display("FAIL sclr_prefill: used=%0d m_valid=%b m_data=%h expected 10 1 10", used_words, m_valid, m_data);
        end
        tick();
        sclr    = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        m_ready = 1'b1;
        tick();
        sclr    = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({used_words, m_valid, s_ready, empty} !== {6'd0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sclr_state: used=%0d m_valid=%b s_ready=%b empty=%b expected 0 0 1 1",
                     used_words, m_valid, s_ready, empty);
        end
        tick();
        s_valid = 1'b1;
        s_data  = 8'h77;
        tick();
        s_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!m_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h77 || used_words !== 6'd1) begin
            n_fail++;
            $display("FAIL sclr_first_out: m_valid=%b m_data=%h used=%0d expected 1 77 1", m_valid, m_data, used_words);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (empty !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sclr_leftover: empty=%b m_valid=%b expected 1 0", empty, m_valid);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int waited;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h50 + i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (used_words !== 6'd5 || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_prefill: used=%0d m_valid=%b expected 5 1", used_words, m_valid);
        end
        #2 arst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, m_valid, used_words, empty, full} !== {1'b0, 1'b0, 6'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL arst_immediate: s_ready=%b m_valid=%b used=%0d empty=%b full=%b expected 0 0 0 1 1",
                     s_ready, m_valid, used_words, empty, full);
        end
        tick();
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        s_data  = 8'h3C;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_ready: s_ready=%b expected 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!m_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h3C || used_words !== 6'd1) begin
            n_fail++;
            $display("FAIL arst_first_out: m_valid=%b m_data=%h used=%0d expected 1 3c 1", m_valid, m_data, used_words);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_sclr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
